md_sequencer: RTL and testbench
===============================

// Module: md_sequencer
// PURPOSE
//  Multi-cycle scheduler for the multiply/divide resource and HI/LO registers.
//  Sits at EX and consumes the EX-stage MD controls: MDFunc, MDSign, MDHIWB, MDLOWB.
//  Runs mult/div for a fixed latency and holds HI/LO.
//  Raises a stall request to the stall detector while an MD-dependent instruction must wait.
//  Aborts in-flight work on exception entry.
// PARAMETERS
//  WIDTH       32  operand / HI / LO width
//  MUL_CYCLES  5   busy cycles for mult/multu (>=1)
//  DIV_CYCLES  10  busy cycles for div/divu (>=1)
// PORTS
//  clk        in   1      clock
//  reset      in   1      asynchronous, active-high reset
//  md_func    in   3      EX MDFunc: 0 none, 1 mthi, 2 mtlo, 3 mul, 4 div
//  md_sign    in   1      1 = signed mult/div
//  src_a      in   WIDTH  rs value (dividend / multiplicand / mthi-mtlo data)
//  src_b      in   WIDTH  rt value (divisor / multiplier)
//  rd_hi      in   1      EX instr is mfhi (MDHIWB)
//  rd_lo      in   1      EX instr is mflo (MDLOWB)
//  md_cancel  in   1      exception/flush: kill in-flight op, ignore this cycle's request
//  busy       out  1      op in flight
//  stall_req  out  1      hold EX (and the stages before it) this cycle
//  hi         out  WIDTH  HI register
//  lo         out  WIDTH  LO register
// BEHAVIOUR
//  Reset (async): state=IDLE, cnt=0, hi=0, lo=0, latched operands=0, busy=0, stall_req=0.
//  FSM states: IDLE, MUL, DIV. busy = (state!=IDLE). cnt width = $clog2(max cycles)+1.
//  IDLE, no cancel:
//   - md_func=3 -> latch a, b, sign; state=MUL; cnt=MUL_CYCLES-1.
//   - md_func=4 -> same latch; state=DIV; cnt=DIV_CYCLES-1.
//   - md_func=1 -> hi<=src_a next edge. md_func=2 -> lo<=src_a next edge.
//  MUL/DIV, no cancel:
//   - cnt!=0: cnt<=cnt-1.
//   - cnt==0: commit hi/lo from the latched operands; state=IDLE.
//  Result: busy is high for exactly N cycles after the issue edge; the new hi/lo is visible the cycle busy falls.
//  stall_req = busy && (md_func!=0 || rd_hi || rd_lo). It is combinational and includes the final busy cycle.
//   - A stalled request must be held stable by the pipeline.
//   - It is accepted on the first cycle after busy falls.
//   - A new mul/div cannot issue while busy. Back-to-back ops serialise.
//  mul: 2*WIDTH product of the latched operands, signed or unsigned per sign; hi=upper half, lo=lower half.
//  div: lo=quotient truncated toward zero; hi=remainder, taking the sign of the dividend.
//  Divide by zero (b==0): lo={WIDTH{1}}, hi=a, for both signed and unsigned.
//  Signed overflow (a=0x80000000, b=-1): lo=0x80000000, hi=0.
//  md_cancel=1 has priority over everything:
//   - state=IDLE, cnt=0; hi/lo unchanged.
//   - A commit due on that same edge is dropped.
//   - A request in the same cycle (including mthi/mtlo) is not accepted.
//   - stall_req is forced to 0 while md_cancel=1.
//  Operands are latched at issue. Later changes on src_a/src_b do not affect the result.
// STRUCTURE
//  Package md_pkg:
//   - md_func_e: MD_NONE=0, MD_MTHI=1, MD_MTLO=2, MD_MUL=3, MD_DIV=4 (matches the controller's MDFunc encoding).
//   - md_state_e: IDLE, MUL, DIV.
//  Sub-module md_arith: purely combinational.
//   - In: a, b, sign, is_div. Out: res_hi, res_lo.
//   - Covers the div-by-zero and overflow rules.
//  md_sequencer holds the FSM, counter, operand latches, HI/LO and stall logic.
// TESTING
//  1. mult, a=-3 (0xFFFFFFFD), b=5, sign=1, MUL_CYCLES=5
//     -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
//  2. divu 7/2 -> lo=3, hi=1.
//     div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     div by 0, a=9 -> lo=0xFFFFFFFF, hi=9.
//  3. mflo (rd_lo=1) held from the cycle after a mult issue
//     -> stall_req=1 for 5 cycles; the first unstalled cycle shows lo=product.
//  4. Start a div, assert md_cancel on busy cycle 3 -> busy=0 next cycle, hi/lo keep prior values.
//     Cancel together with an IDLE mthi -> hi unchanged.
//  5. mthi 0x1234 then mtlo 0x5678 on consecutive cycles while IDLE
//     -> hi=0x1234, lo=0x5678, no stall.
//     mthi during busy -> stalled until busy falls, then applied.
//  6. Assert reset mid-mult -> immediately busy=0, stall_req=0, hi=lo=0.
//     After release, a new mult completes normally.

Source files
------------

// File: rtl/md_pkg.sv
// Shared types for the multiply/divide sequencer.
//   md_func_e  : EX-stage MDFunc encoding as produced by the controller
//   md_state_e : sequencer FSM states
//   max_cycles : larger of two latencies, used to size the busy counter
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE = 3'd0,
    MD_MTHI = 3'd1,
    MD_MTLO = 3'd2,
    MD_MUL  = 3'd3,
    MD_DIV  = 3'd4
  } md_func_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } md_state_e;

  function automatic int max_cycles(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/md_if.sv
// EX-stage interface between the pipeline and the multiply/divide sequencer.
//   master : pipeline side, drives the MD request and reads HI/LO/stall
//   slave  : sequencer side
// Signals: md_func (MDFunc), md_sign, src_a (rs), src_b (rt), rd_hi (mfhi),
//          rd_lo (mflo), md_cancel (exception flush), busy, stall_req, hi, lo.
interface md_if #(
  parameter int WIDTH = 32
);
  logic [2:0]       md_func;
  logic             md_sign;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             rd_hi;
  logic             rd_lo;
  logic             md_cancel;
  logic             busy;
  logic             stall_req;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output md_func, md_sign, src_a, src_b, rd_hi, rd_lo, md_cancel,
    input  busy, stall_req, hi, lo
  );

  modport slave (
    input  md_func, md_sign, src_a, src_b, rd_hi, rd_lo, md_cancel,
    output busy, stall_req, hi, lo
  );
endinterface

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath.
//   a, b    : latched operands
//   sign    : 1 = signed operation
//   is_div  : 1 = divide, 0 = multiply
//   res_hi  : product upper half, or remainder
//   res_lo  : product lower half, or quotient
// Divide by zero gives lo = all ones, hi = a. Signed MIN / -1 gives
// lo = MIN, hi = 0.
module md_arith
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sign,
  input  logic             is_div,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  // Extending both operands to 2*WIDTH makes one truncated multiply valid
  // for both the signed and the unsigned case.
  function automatic logic [2*WIDTH-1:0] mul_full(
    input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic sgn
  );
    logic signed [2*WIDTH-1:0] ex;
    logic signed [2*WIDTH-1:0] ey;
    ex = sgn ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
    ey = sgn ? {{WIDTH{y[WIDTH-1]}}, y} : {{WIDTH{1'b0}}, y};
    return ex * ey;
  endfunction

  // Returns {remainder, quotient}. Signed division works on magnitudes,
  // then restores signs: quotient truncates toward zero, remainder follows
  // the dividend.
  function automatic logic [2*WIDTH-1:0] div_full(
    input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic sgn
  );
    logic             x_neg;
    logic             y_neg;
    logic [WIDTH-1:0] mx;
    logic [WIDTH-1:0] my;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    x_neg = sgn & x[WIDTH-1];
    y_neg = sgn & y[WIDTH-1];
    mx    = x_neg ? -x : x;
    my    = y_neg ? -y : y;
    if (y == '0) begin
      return {x, {WIDTH{1'b1}}};
    end
    if (sgn && (x == {1'b1, {(WIDTH-1){1'b0}}}) && (y == {WIDTH{1'b1}})) begin
      return {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
    end
    q = mx / my;
    r = mx % my;
    return {(x_neg ? -r : r), ((x_neg ^ y_neg) ? -q : q)};
  endfunction

  logic [2*WIDTH-1:0] full;

  always_comb begin
    full   = is_div ? div_full(a, b, sign) : mul_full(a, b, sign);
    res_hi = full[2*WIDTH-1:WIDTH];
    res_lo = full[WIDTH-1:0];
  end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle scheduler for the multiply/divide unit and the HI/LO registers.
// Ports:
//   clk   : clock
//   reset : asynchronous active-high reset
//   bus   : md_if slave modport (EX-stage MD controls in; busy, stall_req,
//           hi, lo out)
// A mult/div latches its operands on issue and keeps busy high for exactly
// MUL_CYCLES / DIV_CYCLES cycles; HI/LO update on the edge busy falls.
// mthi/mtlo write directly when idle. Any MD-dependent instruction seen
// while busy raises stall_req; md_cancel aborts everything at once.
module md_sequencer
  import md_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic clk,
  input logic reset,
  md_if.slave bus
);

  localparam int CNT_W = $clog2(max_cycles(MUL_CYCLES, DIV_CYCLES)) + 1;

  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sign;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  md_func_e         func;

  assign func = md_func_e'(bus.md_func);

  md_arith #(.WIDTH(WIDTH)) u_arith (
    .a      (op_a),
    .b      (op_b),
    .sign   (op_sign),
    .is_div (state == DIV),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busy_q  <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      op_sign <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (bus.md_cancel) begin
      // Abort: drops any commit due this edge and ignores this cycle's request.
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          case (func)
            MD_MUL: begin
              op_a    <= bus.src_a;
              op_b    <= bus.src_b;
              op_sign <= bus.md_sign;
              cnt     <= CNT_W'(MUL_CYCLES - 1);
              state   <= MUL;
              busy_q  <= 1'b1;
            end
            MD_DIV: begin
              op_a    <= bus.src_a;
              op_b    <= bus.src_b;
              op_sign <= bus.md_sign;
              cnt     <= CNT_W'(DIV_CYCLES - 1);
              state   <= DIV;
              busy_q  <= 1'b1;
            end
            MD_MTHI: hi_q <= bus.src_a;
            MD_MTLO: lo_q <= bus.src_a;
            default: ;
          endcase
        end
        MUL, DIV: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            hi_q   <= res_hi;
            lo_q   <= res_lo;
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  // Combinational so the pipeline is held in the same cycle it presents an
  // MD-dependent instruction, including the final busy cycle.
  assign bus.stall_req = busy_q && !bus.md_cancel &&
                         ((bus.md_func != 3'd0) || bus.rd_hi || bus.rd_lo);

endmodule

// File: tb/tb_md_sequencer.sv
module tb_md_sequencer;
  import md_pkg::*;

  localparam int WIDTH      = 32;
  localparam int MUL_CYCLES = 5;
  localparam int DIV_CYCLES = 10;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  md_if #(.WIDTH(WIDTH)) bus ();

  md_sequencer #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: full-precision arithmetic on native 64-bit / int types.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint pa, pb;
    logic [63:0] ua, ub;
    if (s) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      return pa * pb;
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  // Returns {hi, lo} = {remainder, quotient}.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    int sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
      return {r, q};
    end
    return {a % b, a / b};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.md_func   = 3'd0;
    bus.md_sign   = 1'b0;
    bus.src_a     = $urandom;
    bus.src_b     = $urandom;
    bus.rd_hi     = 1'b0;
    bus.rd_lo     = 1'b0;
    bus.md_cancel = 1'b0;
  endtask

  // Issues one mult/div, scrambles the operand inputs, and counts busy cycles.
  task automatic run_op(input logic [2:0] f, input logic s, input logic [31:0] a,
                        input logic [31:0] b, output int ncyc);
    bus.md_func = f;
    bus.md_sign = s;
    bus.src_a   = a;
    bus.src_b   = b;
    tick();
    idle_inputs();
    ncyc = 0;
    while (bus.busy === 1'b1 && ncyc < 64) begin
      ncyc++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_checks++;
    if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", bus.stall_req); end
    n_checks++;
    if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h want 0", bus.hi); end
    n_checks++;
    if (bus.lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h want 0", bus.lo); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mthi_mtlo();
    idle_inputs();
    bus.md_func = MD_MTHI;
    bus.src_a   = 32'h1234;
    #1;
    n_checks++;
    if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL mthi_stall got %b want 0", bus.stall_req); end
    tick();
    bus.md_func = MD_MTLO;
    bus.src_a   = 32'h5678;
    #1;
    n_checks++;
    if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL mtlo_stall got %b want 0", bus.stall_req); end
    tick();
    idle_inputs();
    n_checks++;
    if (bus.hi !== 32'h1234) begin n_fail++; $display("FAIL mthi_value got %h want 00001234", bus.hi); end
    n_checks++;
    if (bus.lo !== 32'h5678) begin n_fail++; $display("FAIL mtlo_value got %h want 00005678", bus.lo); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mthi_mtlo_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_mul();
    int n;
    logic [31:0] a, b;
    logic s;
    logic [63:0] exp;
    run_op(MD_MUL, 1'b1, 32'hFFFF_FFFD, 32'd5, n);
    n_checks++;
    if (n !== MUL_CYCLES) begin n_fail++; $display("FAIL mul_busy_cycles got %0d want %0d", n, MUL_CYCLES); end
    n_checks++;
    if (bus.hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mul_neg3x5_hi got %h want ffffffff", bus.hi); end
    n_checks++;
    if (bus.lo !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mul_neg3x5_lo got %h want fffffff1", bus.lo); end
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      if (i == 0) begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; s = 1'b0; end
      if (i == 1) begin a = 32'h8000_0000; b = 32'h8000_0000; s = 1'b1; end
      exp = ref_mul(a, b, s);
      run_op(MD_MUL, s, a, b, n);
      n_checks++;
      if (n !== MUL_CYCLES) begin n_fail++; $display("FAIL mul_rand_cycles got %0d want %0d", n, MUL_CYCLES); end
      n_checks++;
      if ({bus.hi, bus.lo} !== exp) begin
        n_fail++;
        $display("FAIL mul_rand a=%h b=%h s=%b got %h_%h want %h", a, b, s, bus.hi, bus.lo, exp);
      end
    end
  endtask

  task automatic test_div();
    int n;
    logic [31:0] da [6] = '{32'd7, 32'hFFFF_FFF9, 32'd9, 32'd9, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] db [6] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic        ds [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] eh [6] = '{32'd1, 32'hFFFF_FFFF, 32'd9, 32'd9, 32'd0, 32'h8000_0000};
    logic [31:0] el [6] = '{32'd3, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    logic [31:0] a, b;
    logic s;
    logic [63:0] exp;
    for (int i = 0; i < 6; i++) begin
      run_op(MD_DIV, ds[i], da[i], db[i], n);
      n_checks++;
      if (n !== DIV_CYCLES) begin n_fail++; $display("FAIL div_busy_cycles got %0d want %0d", n, DIV_CYCLES); end
      n_checks++;
      if (bus.hi !== eh[i] || bus.lo !== el[i]) begin
        n_fail++;
        $display("FAIL div_directed%0d got hi=%h lo=%h want hi=%h lo=%h", i, bus.hi, bus.lo, eh[i], el[i]);
      end
    end
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(1, 1000));
      s = 1'($urandom_range(0, 1));
      exp = ref_div(a, b, s);
      run_op(MD_DIV, s, a, b, n);
      n_checks++;
      if ({bus.hi, bus.lo} !== exp) begin
        n_fail++;
        $display("FAIL div_rand a=%h b=%h s=%b got %h_%h want %h", a, b, s, bus.hi, bus.lo, exp);
      end
    end
  endtask

  task automatic test_stall();
    int n;
    logic [31:0] a, b, x;
    logic [63:0] exp;
    a = $urandom;
    b = $urandom;
    x = $urandom;
    exp = ref_mul(a, b, 1'b1);
    idle_inputs();
    bus.md_func = MD_MUL; bus.md_sign = 1'b1; bus.src_a = a; bus.src_b = b;
    tick();
    idle_inputs();
    bus.rd_lo = 1'b1;
    #1;
    n = 0;
    while (bus.stall_req === 1'b1 && n < 64) begin n++; tick(); #1; end
    n_checks++;
    if (n !== MUL_CYCLES) begin n_fail++; $display("FAIL mflo_stall_cycles got %0d want %0d", n, MUL_CYCLES); end
    n_checks++;
    if (bus.lo !== exp[31:0]) begin n_fail++; $display("FAIL mflo_after_stall got %h want %h", bus.lo, exp[31:0]); end

    // mthi held through a busy mult: stalled, then applied after the commit.
    idle_inputs();
    bus.md_func = MD_MUL; bus.md_sign = 1'b0; bus.src_a = a; bus.src_b = b;
    exp = ref_mul(a, b, 1'b0);
    tick();
    bus.md_func = MD_MTHI; bus.src_a = x;
    #1;
    n = 0;
    while (bus.stall_req === 1'b1 && n < 64) begin n++; tick(); #1; end
    n_checks++;
    if (n !== MUL_CYCLES) begin n_fail++; $display("FAIL mthi_busy_stall got %0d want %0d", n, MUL_CYCLES); end
    n_checks++;
    if (bus.hi !== exp[63:32]) begin n_fail++; $display("FAIL mthi_busy_commit got %h want %h", bus.hi, exp[63:32]); end
    tick();
    idle_inputs();
    n_checks++;
    if (bus.hi !== x || bus.lo !== exp[31:0]) begin
      n_fail++;
      $display("FAIL mthi_busy_apply got hi=%h lo=%h want hi=%h lo=%h", bus.hi, bus.lo, x, exp[31:0]);
    end
  endtask

  task automatic test_cancel();
    logic [31:0] h0, l0;
    h0 = 32'hAAAA_0000;
    l0 = 32'h0000_BBBB;
    idle_inputs();
    bus.md_func = MD_MTHI; bus.src_a = h0; tick();
    bus.md_func = MD_MTLO; bus.src_a = l0; tick();
    idle_inputs();
    bus.md_func = MD_DIV; bus.md_sign = 1'b0; bus.src_a = 32'd100; bus.src_b = 32'd7;
    tick();
    idle_inputs();
    tick();
    tick();
    bus.md_cancel = 1'b1;
    bus.rd_hi     = 1'b1;
    #1;
    n_checks++;
    if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL cancel_forces_stall got %b want 0", bus.stall_req); end
    tick();
    idle_inputs();
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL cancel_busy got %b want 0", bus.busy); end
    repeat (DIV_CYCLES + 2) tick();
    n_checks++;
    if (bus.hi !== h0 || bus.lo !== l0) begin
      n_fail++;
      $display("FAIL cancel_div_hilo got hi=%h lo=%h want hi=%h lo=%h", bus.hi, bus.lo, h0, l0);
    end
    bus.md_func = MD_MTHI; bus.src_a = 32'hDEAD_BEEF; bus.md_cancel = 1'b1;
    tick();
    idle_inputs();
    n_checks++;
    if (bus.hi !== h0) begin n_fail++; $display("FAIL cancel_mthi got %h want %h", bus.hi, h0); end
    // Cancel on the very edge the mult would commit.
    bus.md_func = MD_MUL; bus.md_sign = 1'b0; bus.src_a = 32'd3; bus.src_b = 32'd4;
    tick();
    idle_inputs();
    repeat (MUL_CYCLES - 1) tick();
    bus.md_cancel = 1'b1;
    tick();
    idle_inputs();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.hi !== h0 || bus.lo !== l0) begin
      n_fail++;
      $display("FAIL cancel_on_commit got busy=%b hi=%h lo=%h want busy=0 hi=%h lo=%h",
               bus.busy, bus.hi, bus.lo, h0, l0);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] a1, b1, a2, b2;
    logic [63:0] e1, e2;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom_range(1, 5000);
    e1 = ref_mul(a1, b1, 1'b1);
    e2 = ref_div(a2, b2, 1'b1);
    idle_inputs();
    bus.md_func = MD_MUL; bus.md_sign = 1'b1; bus.src_a = a1; bus.src_b = b1;
    tick();
    bus.md_func = MD_DIV; bus.src_a = a2; bus.src_b = b2;
    #1;
    n = 0;
    while (bus.stall_req === 1'b1 && n < 64) begin n++; tick(); #1; end
    n_checks++;
    if (n !== MUL_CYCLES) begin n_fail++; $display("FAIL b2b_stall got %0d want %0d", n, MUL_CYCLES); end
    n_checks++;
    if ({bus.hi, bus.lo} !== e1) begin n_fail++; $display("FAIL b2b_mul got %h_%h want %h", bus.hi, bus.lo, e1); end
    tick();
    idle_inputs();
    n = 0;
    while (bus.busy === 1'b1 && n < 64) begin n++; tick(); end
    n_checks++;
    if (n !== DIV_CYCLES) begin n_fail++; $display("FAIL b2b_div_cycles got %0d want %0d", n, DIV_CYCLES); end
    n_checks++;
    if ({bus.hi, bus.lo} !== e2) begin n_fail++; $display("FAIL b2b_div got %h_%h want %h", bus.hi, bus.lo, e2); end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [31:0] a, b;
    logic [63:0] exp;
    idle_inputs();
    bus.md_func = MD_MTHI; bus.src_a = 32'hFFFF_0000; tick();
    bus.md_func = MD_MUL; bus.src_a = 32'd11; bus.src_b = 32'd13;
    tick();
    idle_inputs();
    bus.rd_lo = 1'b1;
    tick();
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.stall_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_ctrl got busy=%b stall=%b want 0 0", bus.busy, bus.stall_req);
    end
    n_checks++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_hilo got hi=%h lo=%h want 0 0", bus.hi, bus.lo);
    end
    tick();
    reset = 1'b0;
    idle_inputs();
    tick();
    a = $urandom; b = $urandom;
    exp = ref_mul(a, b, 1'b0);
    run_op(MD_MUL, 1'b0, a, b, n);
    n_checks++;
    if (n !== MUL_CYCLES || {bus.hi, bus.lo} !== exp) begin
      n_fail++;
      $display("FAIL reset_mid_recover got cycles=%0d %h_%h want cycles=%0d %h",
               n, bus.hi, bus.lo, MUL_CYCLES, exp);
    end
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_mul();
    test_div();
    test_stall();
    test_cancel();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
